spwm_phase_sequencer: RTL

//  Phase-accumulator controller that drives the three-phase sine-table ROM.

---
 rtl/spwm_cfg_if.sv | 14 +
 rtl/spwm_phase_sequencer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/spwm_cfg_if.sv
// Configuration handshake between the control plane and the SPWM phase sequencer.
// A config word transfers on any clock where cfg_valid and cfg_ready are both high.
interface spwm_cfg_if #(
  parameter int ACC_BITS = 32,
  parameter int DIV_BITS = 16
);
  logic                cfg_valid;
  logic                cfg_ready;
  logic [ACC_BITS-1:0] cfg_fcw;
  logic [DIV_BITS-1:0] cfg_div;

  modport master (output cfg_valid, output cfg_fcw, output cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_fcw, input cfg_div, output cfg_ready);
endinterface

// File: rtl/spwm_phase_sequencer.sv
// Phase accumulator feeding the three-phase sine ROM: a prescaled sample tick steps
// the accumulator by fcw, and a stop request drains to the next period boundary.
module spwm_phase_sequencer #(
  parameter int ADDR_BITS = 16,
  parameter int ACC_BITS  = 32,
  parameter int DIV_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  spwm_cfg_if.slave            cfg,
  input  logic                 i_start,
  input  logic                 i_stop,
  output logic                 o_rom_en,
  output logic [ADDR_BITS-1:0] o_rom_addr,
  output logic                 o_sample_tick,
  output logic                 o_period_wrap,
  output logic                 o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [ACC_BITS-1:0]  r_acc;
  logic [DIV_BITS-1:0]  r_presc;
  logic [ACC_BITS-1:0]  r_fcw;
  logic [DIV_BITS-1:0]  r_div;
  logic [ACC_BITS-1:0]  r_fcw_sh;
  logic [DIV_BITS-1:0]  r_div_sh;
  logic                 r_pend;
  logic                 r_busy;
  logic [ADDR_BITS-1:0] r_rom_addr;
  logic                 r_tick;
  logic                 r_wrap;

  logic                 w_accept;
  logic                 w_tick;
  logic [ACC_BITS:0]    w_sum;
  logic                 w_carry;
  logic                 w_drain_exit;

  assign cfg.cfg_ready = (r_state != S_DRAIN);
  assign w_accept      = cfg.cfg_valid & cfg.cfg_ready;
  assign w_tick        = (r_state != S_IDLE) && (r_presc == r_div);
  assign w_sum         = {1'b0, r_acc} + {1'b0, r_fcw};
  assign w_carry       = w_sum[ACC_BITS];
  // A zero step can never wrap, so DRAIN gives up at once rather than hang.
  assign w_drain_exit  = (r_state == S_DRAIN) && !i_start &&
                         ((r_fcw == '0) || (w_tick && w_carry));

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_next = S_RUN;
      S_RUN:   if (i_stop)  w_next = S_DRAIN;
      S_DRAIN: begin
        if (i_start)           w_next = S_RUN;
        else if (w_drain_exit) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_presc    <= '0;
      r_fcw      <= '0;
      r_div      <= '0;
      r_fcw_sh   <= '0;
      r_div_sh   <= '0;
      r_pend     <= 1'b0;
      r_busy     <= 1'b0;
      r_rom_addr <= '0;
      r_tick     <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;

      if (r_state == S_IDLE) begin
        // Idle config goes straight to the live registers; a leftover shadow is flushed.
        if (w_accept) begin
          r_fcw <= cfg.cfg_fcw;
          r_div <= cfg.cfg_div;
        end else if (r_pend) begin
          r_fcw <= r_fcw_sh;
          r_div <= r_div_sh;
        end
        r_pend <= 1'b0;
        if (i_start) begin
          r_acc      <= '0;
          r_presc    <= '0;
          r_rom_addr <= '0;
        end
      end else begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;

        if (w_tick && r_pend) begin
          r_fcw  <= r_fcw_sh;
          r_div  <= r_div_sh;
          r_pend <= 1'b0;
        end
        if (w_accept) begin
          r_fcw_sh <= cfg.cfg_fcw;
          r_div_sh <= cfg.cfg_div;
          r_pend   <= 1'b1;
        end

        if (w_drain_exit) begin
          r_acc      <= '0;
          r_rom_addr <= '0;
          r_tick     <= w_tick && w_carry;
          r_wrap     <= w_tick && w_carry;
        end else if (w_tick) begin
          r_acc      <= w_sum[ACC_BITS-1:0];
          r_rom_addr <= w_sum[ACC_BITS-1 -: ADDR_BITS];
          r_tick     <= 1'b1;
          r_wrap     <= w_carry;
        end
      end
    end
  end

  assign o_rom_en      = r_busy;
  assign o_busy        = r_busy;
  assign o_rom_addr    = r_rom_addr;
  assign o_sample_tick = r_tick;
  assign o_period_wrap = r_wrap;

endmodule
